dc_servo: RTL and testbench

DC_SERVO -- requirements
Module: dc_servo

---
 rtl/gnss_dsp_pkg.sv | 33 +++
 rtl/dc_servo.sv | 93 +++++++++
 tb/tb_dc_servo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gnss_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gnss_dsp_pkg
// Brief    : Shared sample-format constants and helpers for the GNSS front-end
//            DSP blocks (dc_servo, quantize, histogram, dc_sum).
// Revision : 1.0 - initial release
// ============================================================================
package gnss_dsp_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] ZERO_CODE = 8'h80;

  localparam int CORR_MAX = (2 ** (SAMPLE_W - 1)) - 1;
  localparam int CORR_MIN = -(2 ** (SAMPLE_W - 1));

  typedef logic [SAMPLE_W-1:0]        sample_t;
  typedef logic signed [SAMPLE_W-1:0] corr_t;

  // Clamp a wide signed value into the two's-complement correction range.
  function automatic corr_t sat_corr(input logic signed [31:0] v);
    corr_t r;
    if (v > CORR_MAX) begin
      r = corr_t'(CORR_MAX);
    end else if (v < CORR_MIN) begin
      r = corr_t'(CORR_MIN);
    end else begin
      r = corr_t'(v[SAMPLE_W-1:0]);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_servo.sv
`default_nettype none
// ============================================================================
// Module   : dc_servo
// Brief    : Windowed-mean DC offset servo with manual override, one rail.
// Revision : 1.0 - initial release
// ============================================================================
module dc_servo
  import gnss_dsp_pkg::*;
#(
  parameter int WIN_LOG2 = 12,
  parameter int STEP     = 1,
  parameter int DEADBAND = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] x,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] manual_dc,
  output logic [SAMPLE_W-1:0] y,
  output logic [SAMPLE_W-1:0] dc,
  output logic [SAMPLE_W-1:0] mean,
  output logic                window_done
);

  localparam int ACC_W = SAMPLE_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] c_cnt_last = '1;
  localparam logic [WIN_LOG2-1:0] c_cnt_one  = WIN_LOG2'(1);

  sample_t                   r_y;
  sample_t                   r_dc;
  sample_t                   r_mean;
  logic                      r_window_done;
  logic signed [ACC_W-1:0]   r_acc;
  logic [WIN_LOG2-1:0]       r_cnt;

  logic signed [SAMPLE_W-1:0] w_centered;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [31:0]         w_sum_ext;
  logic signed [31:0]         w_dc_ext;
  logic                       w_wrap;
  sample_t                    w_dc_servo;

  // Removing the 0x80 bias of offset-binary yields the signed sample value.
  assign w_centered = $signed(r_y - ZERO_CODE);
  // The current sample is folded in here so the window-end sum is complete.
  assign w_sum      = r_acc + {{WIN_LOG2{w_centered[SAMPLE_W-1]}}, w_centered};
  assign w_sum_ext  = {{(32-ACC_W){w_sum[ACC_W-1]}}, w_sum};
  assign w_dc_ext   = {{(32-SAMPLE_W){r_dc[SAMPLE_W-1]}}, r_dc};
  assign w_wrap     = (r_cnt == c_cnt_last);

  always_comb begin
    w_dc_servo = r_dc;
    if (w_sum_ext > DEADBAND) begin
      w_dc_servo = sat_corr(w_dc_ext - STEP);
    end else if (w_sum_ext < -DEADBAND) begin
      w_dc_servo = sat_corr(w_dc_ext + STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y           <= ZERO_CODE;
      r_dc          <= '0;
      r_mean        <= '0;
      r_window_done <= 1'b0;
      r_acc         <= '0;
      r_cnt         <= '0;
    end else begin
      r_y           <= x + r_dc;
      r_cnt         <= r_cnt + c_cnt_one;
      r_window_done <= w_wrap;
      if (w_wrap) begin
        r_mean <= w_sum[WIN_LOG2 +: SAMPLE_W];
        r_acc  <= '0;
      end else begin
        r_acc  <= w_sum;
      end
      // Manual override wins, including on a window-end cycle.
      if (!enable) begin
        r_dc <= manual_dc;
      end else if (w_wrap) begin
        r_dc <= w_dc_servo;
      end
    end
  end

  assign y           = r_y;
  assign dc          = r_dc;
  assign mean        = r_mean;
  assign window_done = r_window_done;

endmodule
`default_nettype wire

// File: tb/tb_dc_servo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_servo
// Brief    : Directed and random checks of dc_servo against a window-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_servo;

  localparam int WL   = 4;
  localparam int STP  = 1;
  localparam int DB   = 4;
  localparam int WIN  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x = 8'h00;
  logic       enable = 1'b0;
  logic [7:0] manual_dc = 8'h00;
  logic [7:0] y;
  logic [7:0] dc;
  logic [7:0] mean;
  logic       window_done;

  dc_servo #(.WIN_LOG2(WL), .STEP(STP), .DEADBAND(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .enable      (enable),
    .manual_dc   (manual_dc),
    .y           (y),
    .dc          (dc),
    .mean        (mean),
    .window_done (window_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: outputs as plain integers plus the samples of the open window.
  int m_y, m_dc, m_mean, m_wd;
  int win_q[$];
  int wd_dc_q[$];

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int to_s8(input int v);
    int t;
    t = v & 255;
    return (t >= 128) ? t - 256 : t;
  endfunction

  task automatic model_reset();
    m_y = 128; m_dc = 0; m_mean = 0; m_wd = 0;
    win_q.delete();
  endtask

  task automatic model_edge();
    int next_y, sum, d;
    next_y = (int'(x) + m_dc) & 255;
    win_q.push_back(m_y - 128);
    m_wd = 0;
    if (win_q.size() == WIN) begin
      sum = 0;
      foreach (win_q[i]) sum += win_q[i];
      m_mean = floor_div(sum, WIN) & 255;
      m_wd = 1;
      if (enable) begin
        d = to_s8(m_dc);
        if (sum > DB) d = d - STP;
        else if (sum < -DB) d = d + STP;
        if (d > 127) d = 127;
        if (d < -128) d = -128;
        m_dc = d & 255;
      end
      win_q.delete();
    end
    if (!enable) m_dc = int'(manual_dc);
    m_y = next_y;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("y", {24'b0, y}, m_y);
    check("dc", {24'b0, dc}, m_dc);
    check("mean", {24'b0, mean}, m_mean);
    check("window_done", {31'b0, window_done}, m_wd);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    if (window_done === 1'b1) wd_dc_q.push_back(int'(dc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    wd_dc_q.delete();
  endtask

  initial begin
    // Reset held with a non-zero input.
    reset = 1'b1; x = 8'h37;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_y", {24'b0, y}, 32'h80);
    check("rst_dc", {24'b0, dc}, 32'h00);
    check("rst_mean", {24'b0, mean}, 32'h00);
    check("rst_wd", {31'b0, window_done}, 32'h0);
    reset = 1'b0;

    // Manual correction.
    enable = 1'b0; manual_dc = 8'h05; x = 8'h80;
    repeat (40) step();
    check("manual_y", {24'b0, y}, 32'h85);
    check("manual_dc", {24'b0, dc}, 32'h05);
    check("manual_wd_count", wd_dc_q.size(), 2);

    // Convergence from dc=0 with a +3 offset.
    do_reset();
    enable = 1'b1; x = 8'h83;
    repeat (6 * WIN) step();
    check("conv_n", wd_dc_q.size(), 6);
    if (wd_dc_q.size() >= 4) begin
      check("conv_dc1", wd_dc_q[0], 32'hFF);
      check("conv_dc2", wd_dc_q[1], 32'hFE);
      check("conv_dc3", wd_dc_q[2], 32'hFD);
      check("conv_dc4", wd_dc_q[3], 32'hFD);
    end
    check("conv_y", {24'b0, y}, 32'h80);
    check("conv_mean", {24'b0, mean}, 32'h00);

    // Sum inside the deadband leaves dc alone.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      x = (i < 4) ? 8'h81 : 8'h80;
      step();
    end
    check("db_wd", {31'b0, window_done}, 32'h1);
    check("db_dc", {24'b0, dc}, 32'h00);
    check("db_mean", {24'b0, mean}, 32'h00);

    // Saturation at +127.
    do_reset();
    enable = 1'b1; x = 8'h00;
    repeat (135 * WIN) step();
    check("sat_dc", {24'b0, dc}, 32'h7F);

    // Reset mid-window discards the partial window.
    do_reset();
    enable = 1'b1; x = 8'hFF;
    repeat (7) step();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    for (int i = 1; i <= WIN; i++) begin
      x = 8'($urandom_range(0, 255));
      step();
      check("mw_wd_edge", {31'b0, window_done}, (i == WIN) ? 32'h1 : 32'h0);
    end

    // Enable falling on a window-end cycle: manual value wins.
    do_reset();
    enable = 1'b1; x = 8'h90;
    repeat (WIN - 1) step();
    enable = 1'b0; manual_dc = 8'h22;
    step();
    check("fall_wd", {31'b0, window_done}, 32'h1);
    check("fall_dc", {24'b0, dc}, 32'h22);

    // Random traffic with occasional mode changes.
    enable = 1'b1;
    repeat (800) begin
      x = 8'($urandom_range(0, 255));
      manual_dc = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) enable = ~enable;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
